// File: rtl/lmac_phy_emu_pkg.sv
// Shared constants, header layout and FSM states for the PHY-emulator TX capture block.
package lmac_phy_emu_pkg;
    localparam int ADDR_DEPTH = 2048;
    localparam int ADDR_WIDTH = 11;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int MIN_LEN    = 64;
    localparam int MAX_LEN    = 1522;

    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_ERR   = 8'hFE;
    localparam logic [7:0]  XGMII_IDLE  = 8'h07;
    localparam logic [31:0] PRE_WORD0   = 32'h555555FB;
    localparam logic [31:0] SFD_WORD    = 32'hD5555555;

    // Header word layout
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;
    localparam int HDR_ERR_BIT = 16;
    localparam int HDR_SEQ_LSB = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_HDR,
        ST_DROP
    } cap_state_e;

    function automatic logic [31:0] make_hdr(input logic [15:0] len, input logic err,
                                             input logic [7:0] seq);
        logic [31:0] h;
        h                            = '0;
        h[HDR_LEN_LSB +: HDR_LEN_W]  = len;
        h[HDR_ERR_BIT]               = err;
        h[HDR_SEQ_LSB +: 8]          = seq;
        return h;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/tx_pkt_cap2kx32_if.sv
// XGMII TX monitor input, host read port and status outputs of the capture block.
interface tx_pkt_cap2kx32_if;
    import lmac_phy_emu_pkg::*;

    logic                  cap_en;
    logic [31:0]           xgmii_txd;
    logic [3:0]            xgmii_txc;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           rd_data;
    logic [PTR_WIDTH-1:0]  host_rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [31:0]           pkt_cnt;
    logic [15:0]           drop_cnt;
    logic [15:0]           err_cnt;
    logic                  cap_busy;

    modport master (
        output cap_en, xgmii_txd, xgmii_txc, rd_en, rd_addr, host_rd_ptr,
        input  rd_data, wr_ptr, pkt_cnt, drop_cnt, err_cnt, cap_busy
    );

    modport slave (
        input  cap_en, xgmii_txd, xgmii_txc, rd_en, rd_addr, host_rd_ptr,
        output rd_data, wr_ptr, pkt_cnt, drop_cnt, err_cnt, cap_busy
    );
endinterface

// File: rtl/tx_cap_sdpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module tx_cap_sdpram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read sees the pre-write contents on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/tx_pkt_cap2kx32.sv
// XGMII TX capture: strips preamble/SFD and stores each frame behind a one-word
// header in a 2Kx32 circular buffer; wr_ptr only moves on a complete, valid frame.
module tx_pkt_cap2kx32
    import lmac_phy_emu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    tx_pkt_cap2kx32_if.slave bus
);
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    cap_state_e  state_q, state_d;
    ptr_t        base_q, base_d, wr_ptr_q, wr_ptr_d, restart_base;
    logic [15:0] nbytes_q, nbytes_d;
    logic        err_q, err_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    logic        start_hit, term_seen, ctl_err, any_term;
    logic [2:0]  term_lane;
    logic [31:0] data_word;

    // Lane decode: first Terminate lane, control-error lanes ahead of it, payload masking.
    always_comb begin
        start_hit = bus.cap_en && (bus.xgmii_txc == 4'b0001) &&
                    (bus.xgmii_txd[7:0] == XGMII_START);
        term_seen = 1'b0;
        term_lane = 3'd4;
        ctl_err   = 1'b0;
        any_term  = 1'b0;
        data_word = bus.xgmii_txd;
        for (int i = 0; i < 4; i++) begin
            if (bus.xgmii_txc[i] && bus.xgmii_txd[8*i +: 8] == XGMII_TERM) any_term = 1'b1;
            if (!term_seen && bus.xgmii_txc[i]) begin
                if (bus.xgmii_txd[8*i +: 8] == XGMII_TERM) begin
                    term_seen = 1'b1;
                    term_lane = 3'(i);
                end else begin
                    ctl_err = 1'b1;
                end
            end
            if (term_seen) data_word[8*i +: 8] = 8'h00;
        end
    end

    ptr_t        word_ptr, commit_ptr;
    logic [15:0] len_next;
    logic        word_wr, no_room, too_long;

    // nbytes is a multiple of 4 in DATA, so nbytes/4 is the payload word index.
    assign word_ptr   = base_q + ptr_t'(1) + ptr_t'(nbytes_q[15:2]);
    assign no_room    = ptr_t'(word_ptr - bus.host_rd_ptr) >= ptr_t'(ADDR_DEPTH);
    assign len_next   = nbytes_q + (term_seen ? {13'd0, term_lane} : 16'd4);
    assign word_wr    = !term_seen || (term_lane != 3'd0);
    assign too_long   = len_next > 16'(MAX_LEN);
    assign commit_ptr = base_q + ptr_t'(1) + ptr_t'((nbytes_q + 16'd3) >> 2);

    // Next-state, buffer write and counter update.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wr_ptr_d     = wr_ptr_q;
        nbytes_d     = nbytes_q;
        err_d        = err_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        err_cnt_d    = err_cnt_q;
        restart_base = wr_ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = word_ptr[ADDR_WIDTH-1:0];
        mem_wdata    = data_word;
        unique case (state_q)
            ST_IDLE: begin
                if (start_hit) begin
                    state_d  = ST_PRE;
                    base_d   = wr_ptr_q;
                    nbytes_d = '0;
                    err_d    = 1'b0;
                end
            end
            ST_PRE: begin
                state_d = (bus.xgmii_txd == SFD_WORD && bus.xgmii_txc == 4'h0) ? ST_DATA : ST_DROP;
            end
            ST_DATA: begin
                if ((word_wr && no_room) || too_long) begin
                    // Terminate already consumed: no DROP wait, count it now.
                    if (term_seen) begin
                        state_d    = ST_IDLE;
                        drop_cnt_d = sat_inc16(drop_cnt_q);
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    mem_we   = word_wr;
                    nbytes_d = len_next;
                    if (ctl_err)   err_d   = 1'b1;
                    if (term_seen) state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (nbytes_q < 16'(MIN_LEN)) begin
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                end else begin
                    mem_we       = 1'b1;
                    mem_waddr    = base_q[ADDR_WIDTH-1:0];
                    mem_wdata    = make_hdr(nbytes_q, err_q, pkt_cnt_q[7:0]);
                    wr_ptr_d     = commit_ptr;
                    restart_base = commit_ptr;
                    pkt_cnt_d    = pkt_cnt_q + 32'd1;
                    if (err_q) err_cnt_d = sat_inc16(err_cnt_q);
                end
                if (start_hit) begin
                    state_d  = ST_PRE;
                    base_d   = restart_base;
                    nbytes_d = '0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (any_term) begin
                    state_d    = ST_IDLE;
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            wr_ptr_q   <= '0;
            nbytes_q   <= '0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wr_ptr_q   <= wr_ptr_d;
            nbytes_q   <= nbytes_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.pkt_cnt  = pkt_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.cap_busy = (state_q != ST_IDLE);

    tx_cap_sdpram #(.DEPTH(ADDR_DEPTH), .AW(ADDR_WIDTH), .DW(32)) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_tx_pkt_cap2kx32.sv
// Bench for tx_pkt_cap2kx32: frame-level reference model plus directed and random traffic.
module tb_tx_pkt_cap2kx32;
    import lmac_phy_emu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_pkt_cap2kx32_if bus();
    tx_pkt_cap2kx32 dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    bit quiet   = 1'b0;

    logic [7:0]  fb    [0:1599];
    logic [31:0] m_mem [0:2047];
    logic [11:0] m_wr;
    logic [31:0] m_pkt;
    logic [15:0] m_drop, m_errc;
    logic [11:0] last_base;
    int          last_nw;
    bit          last_commit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = '0; m_pkt = '0; m_drop = '0; m_errc = '0; last_commit = 1'b0;
    endtask

    // Whole-frame outcome: drop on bad SFD, bad length, or buffer space; otherwise store.
    task automatic model_frame(input int len, input bit err, input bit bad_sfd);
        int          nw;
        logic [11:0] used;
        logic [31:0] d;
        nw          = (len + 3) / 4;
        used        = m_wr + 12'(nw) - bus.host_rd_ptr;
        last_commit = 1'b0;
        if (bad_sfd || len < MIN_LEN || len > MAX_LEN || used >= 12'd2048) begin
            if (m_drop != 16'hFFFF) m_drop++;
        end else begin
            m_mem[m_wr[10:0]] = {m_pkt[7:0], 7'd0, err, 16'(len)};
            for (int w = 0; w < nw; w++) begin
                d = '0;
                for (int l = 0; l < 4; l++)
                    if (w*4 + l < len) d[8*l +: 8] = fb[w*4 + l];
                m_mem[11'(m_wr + 12'(1 + w))] = d;
            end
            last_base = m_wr; last_nw = nw; last_commit = 1'b1;
            m_wr = m_wr + 12'(1 + nw);
            m_pkt++;
            if (err && m_errc != 16'hFFFF) m_errc++;
        end
    endtask

    // Status outputs must match the model whenever the line has been idle after a frame.
    always @(negedge clk) begin
        if (quiet) begin
            check("wr_ptr",   32'(bus.wr_ptr),   32'(m_wr));
            check("pkt_cnt",  bus.pkt_cnt,       m_pkt);
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
            check("err_cnt",  32'(bus.err_cnt),  32'(m_errc));
            check("cap_busy", 32'(bus.cap_busy), 32'd0);
        end
    end

    task automatic drive(input logic [31:0] d, input logic [3:0] c);
        @(posedge clk); #1;
        bus.xgmii_txd = d;
        bus.xgmii_txc = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive({4{XGMII_IDLE}}, 4'hF);
        if (n >= 2 && !reset) quiet = 1'b1;
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    endtask

    task automatic send_frame(input int len, input int errp, input bit bad_sfd);
        bit          cap;
        logic [31:0] d;
        logic [3:0]  c;
        int          n;
        quiet = 1'b0;
        cap   = bus.cap_en;
        if (errp >= 0) fb[errp] = XGMII_ERR;
        drive(PRE_WORD0, 4'b0001);
        drive(bad_sfd ? 32'h55555555 : SFD_WORD, 4'h0);
        for (int w = 0; w <= len / 4; w++) begin
            for (int l = 0; l < 4; l++) begin
                n = w*4 + l;
                if (n < len)       begin d[8*l +: 8] = fb[n];      c[l] = (n == errp); end
                else if (n == len) begin d[8*l +: 8] = XGMII_TERM; c[l] = 1'b1; end
                else               begin d[8*l +: 8] = XGMII_IDLE; c[l] = 1'b1; end
            end
            drive(d, c);
        end
        if (cap) model_frame(len, errp >= 0, bad_sfd);
    endtask

    task automatic rd_word(input logic [11:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = a[10:0];
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic check_frame(input logic [11:0] base, input int nw);
        logic [31:0] d;
        for (int i = 0; i <= nw; i++) begin
            rd_word(base + 12'(i), d);
            check("mem", d, m_mem[11'(base + 12'(i))]);
        end
    endtask

    task automatic do_reset();
        quiet = 1'b0;
        reset = 1'b1;
        bus.host_rd_ptr = '0;
        idle(2);
        reset = 1'b0;
        model_reset();
        idle(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          len, errp, gap;
        bit          bad;

        bus.cap_en = 1'b1; bus.xgmii_txd = {4{XGMII_IDLE}}; bus.xgmii_txc = 4'hF;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.host_rd_ptr = '0;
        model_reset();
        #1;
        check("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        check("rst_pkt",    bus.pkt_cnt,     32'd0);
        check("rst_drop",   32'(bus.drop_cnt), 32'd0);
        check("rst_busy",   32'(bus.cap_busy), 32'd0);
        check("rst_rdata",  bus.rd_data,     32'd0);
        do_reset();

        // 64-byte frame, Terminate in lane 0
        fill_rand(64); send_frame(64, -1, 1'b0); idle(3);
        check("t1_wr_ptr", 32'(bus.wr_ptr), 32'd17);
        check("t1_pkt", bus.pkt_cnt, 32'd1);
        rd_word(12'd0, d); check("t1_hdr", d, 32'h00000040);
        rd_word(12'd1, d); check("t1_w1", d, {fb[3], fb[2], fb[1], fb[0]});
        check_frame(last_base, last_nw);

        // 65-byte frame, Terminate in lane 1
        do_reset();
        fill_rand(65); send_frame(65, -1, 1'b0); idle(3);
        rd_word(12'd0, d); check("t2_len", 32'(d[15:0]), 32'h41);
        rd_word(12'd17, d); check("t2_last", d, {24'h0, fb[64]});
        check("t2_wr_ptr", 32'(bus.wr_ptr), 32'd18);

        // 63-byte runt
        do_reset();
        fill_rand(63); send_frame(63, -1, 1'b0); idle(3);
        check("t8_drop", 32'(bus.drop_cnt), 32'd1);
        check("t8_wr_ptr", 32'(bus.wr_ptr), 32'd0);

        // Bad SFD, then a good frame lands at address 0
        do_reset();
        fill_rand(64); send_frame(64, -1, 1'b1); idle(3);
        check("t4_drop", 32'(bus.drop_cnt), 32'd1);
        check("t4_pkt", bus.pkt_cnt, 32'd0);
        fill_rand(64); send_frame(64, -1, 1'b0); idle(3);
        rd_word(12'd0, d); check("t4_hdr", d, 32'h00000040);
        check("t4_wr_ptr", 32'(bus.wr_ptr), 32'd17);

        // Error character in lane 2 of data word 5
        do_reset();
        fill_rand(80); send_frame(80, 22, 1'b0); idle(3);
        check("t5_errcnt", 32'(bus.err_cnt), 32'd1);
        rd_word(12'd0, d); check("t5_hdr", d, 32'h00010050);
        rd_word(12'd6, d); check("t5_byte", 32'(d[23:16]), 32'hFE);

        // Back-to-back: second Start lands in the first frame's header cycle
        do_reset();
        fill_rand(64); send_frame(64, -1, 1'b0);
        fill_rand(64); send_frame(64, -1, 1'b0); idle(3);
        check("t6_wr_ptr", 32'(bus.wr_ptr), 32'd34);
        check("t6_pkt", bus.pkt_cnt, 32'd2);
        rd_word(12'd17, d); check("t6_hdr2", d, 32'h01000040);
        check_frame(last_base, last_nw);

        // Fill until no space, then free and wrap past address 2047
        do_reset();
        for (int f = 0; f < 6; f++) begin
            fill_rand(1500); send_frame(1500, -1, 1'b0); idle(3);
        end
        check("t3_drop", 32'(bus.drop_cnt), 32'd1);
        check("t3_wr_ptr", 32'(bus.wr_ptr), 32'd1880);
        bus.host_rd_ptr = 12'd1880;
        fill_rand(1500); send_frame(1500, -1, 1'b0); idle(3);
        check("t3_wrap_ptr", 32'(bus.wr_ptr), 32'd2256);
        check_frame(last_base, last_nw);

        // Reset in the middle of DATA
        quiet = 1'b0;
        drive(PRE_WORD0, 4'b0001);
        drive(SFD_WORD, 4'h0);
        for (int i = 0; i < 3; i++) drive(32'($urandom), 4'h0);
        reset = 1'b1;
        #1;
        check("t7_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        check("t7_pkt", bus.pkt_cnt, 32'd0);
        check("t7_drop", 32'(bus.drop_cnt), 32'd0);
        check("t7_busy", 32'(bus.cap_busy), 32'd0);
        check("t7_rdata", bus.rd_data, 32'd0);
        idle(2);
        reset = 1'b0;
        bus.host_rd_ptr = '0;
        model_reset();
        idle(2);
        fill_rand(64); send_frame(64, -1, 1'b0); idle(3);
        rd_word(12'd0, d); check("t7_hdr", d, 32'h00000040);
        check("t7_wr_ptr2", 32'(bus.wr_ptr), 32'd17);

        // Random traffic against the frame-level model
        do_reset();
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 9))
                0:          len = $urandom_range(50, 63);
                1:          len = $urandom_range(1523, 1530);
                2, 3, 4, 5: len = $urandom_range(64, 200);
                default:    len = $urandom_range(201, 1522);
            endcase
            errp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
            bad  = ($urandom_range(0, 15) == 0);
            bus.cap_en = ($urandom_range(0, 9) != 0);
            fill_rand(len);
            send_frame(len, errp, bad);
            bus.cap_en = 1'b1;
            gap = $urandom_range(0, 3);
            idle(gap);
            if (gap >= 2) begin
                if (last_commit && $urandom_range(0, 2) == 0) check_frame(last_base, last_nw);
                if ($urandom_range(0, 1) == 0) bus.host_rd_ptr = m_wr;
            end
        end
        idle(3);
        quiet = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
